ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
Parametrised AHB-Lite slave memory. Successor to the flat flag-driven external memory model: it decodes the AHB-Lite address/data pipeline itself, supports byte/halfword/word writes, programmable wait states and a two-cycle ERROR response. It sits behind the bus decoder as the system RAM and keeps a side-band monitor read port for the scoreboard.

Parameters:
DATA_W, 32, bus data width; one of 32 or 64.
ADDR_W, 32, HADDR width.
DEPTH, 4096, number of DATA_W-bit words.
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer; range 0..15.

Ports:
HCLK  in  1  bus clock; all state updates on the rising edge.
HRESETn  in  1  asynchronous active-low reset.
HSEL  in  1  slave select from the decoder.
HADDR  in  ADDR_W  byte address.
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HWRITE  in  1  1 = write.
HSIZE  in  3  transfer size: 0=byte, 1=half, 2=word, 3=dword.
HWDATA  in  DATA_W  write data, valid in the data phase.
HREADY  in  1  bus-level ready (HREADYIN).
HRDATA  out  DATA_W  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0 = OKAY, 1 = ERROR.
monitor_flag  in  1  backdoor read enable.
monitor_addr  in  $clog2(DEPTH)  backdoor word index.
monitor_DATA  out  DATA_W  backdoor read data.

Behaviour:
- Reset (HRESETn low, asynchronous): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, registered address-phase fields cleared. Memory contents are NOT reset. Reset mid-transfer abandons the transfer; a pending write is not performed.
- Accept: address phase is accepted on an edge where HSEL & HREADY & HTRANS[1]. The block then registers HADDR, HWRITE and HSIZE. BUSY and IDLE transfers get a zero-wait OKAY and never touch memory.
- Word index = HADDR >> log2(DATA_W/8). Byte lane = HADDR[log2(DATA_W/8)-1:0].
- An accepted transfer is an error if any of these holds:
  - word index >= DEPTH;
  - HSIZE > log2(DATA_W/8);
  - HADDR is not aligned to 2^HSIZE.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
  - On accept (from IDLE, DATA or ERR2): an error transfer goes to ERR1. Otherwise the next state is WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else DATA.
  - WAIT: HREADYOUT=0. Counter decrements each cycle; when it reaches 0, next state is DATA.
  - DATA: HREADYOUT=1, HRESP=0. Transfer completes at this edge. Next state is IDLE if there is no new accept.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state is IDLE, or a new transfer if one is accepted.
- Write: memory is updated on the completing edge of DATA only.
  - Only lanes [lane, lane + 2^HSIZE - 1] are written from the matching HWDATA byte lanes; all other bytes are unchanged.
  - Error transfers never write.
- Read: HRDATA = mem[registered index] (full word, all lanes) combinationally, during WAIT/DATA of a read. HRDATA = 0 in all other states.
  - A read in the data phase immediately after a write to the same word returns the new data, because the write commits first.
- Back-to-back: with WAIT_STATES=0, one transfer completes per cycle, with address phase N+1 overlapping data phase N.
- monitor_DATA = mem[monitor_addr] when monitor_flag=1, else 0. Purely combinational, no latch; an out-of-range monitor_addr returns 0.

Optional Feature:
AHB_SRAM_WAIT_RANDOM_EN.
- Defined: each OKAY transfer inserts 0..WAIT_STATES wait cycles. The count is taken from an internal 16-bit LFSR (seed 16'hACE1 at reset, advanced once per accept), reduced modulo WAIT_STATES+1.
- Undefined: a fixed WAIT_STATES cycles per transfer.
- ERROR timing is identical in both builds.

Decomposition:
- Package ahb_sram_pkg holds:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ);
  - hsize_t enum;
  - sram_state_t enum (IDLE/WAIT/DATA/ERR1/ERR2);
  - HRESP_OKAY/HRESP_ERROR constants;
  - function byte_mask(size, lane) returning a DATA_W/8-bit strobe.
- One sub-module: ahb_sram_array (DEPTH x DATA_W storage with byte-strobe write port, one combinational read port and the monitor read port). The FSM stays in the top.

Test Plan:
- Reset, then word write 0xDEADBEEF to 0x10 and read 0x10 (WAIT_STATES=0) -> HREADYOUT stays 1; HRDATA=0xDEADBEEF in the read data phase; monitor_addr=4 gives the same value.
- Byte write 0x5A to 0x11 (HSIZE=0) over 0xDEADBEEF -> word at index 4 reads 0xDEAD5AEF; half write 0x1234 to 0x12 -> 0x12345AEF.
- WAIT_STATES=3, word read -> HREADYOUT low for exactly 3 cycles, then high for 1 with valid data; write commits only on the high cycle.
- Read from HADDR=0x4000 (index 4096), then misaligned half at 0x1 -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1); memory is unchanged.
- Back-to-back NONSEQ write 0xA5A5A5A5 to 0x20 followed immediately by a read of 0x20 -> the read returns 0xA5A5A5A5 with no stall.
- Assert HRESETn low during a WAIT-state write -> outputs return to reset values immediately; the target word keeps its old value; an IDLE HTRANS gets an OKAY zero-wait response.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// +------------------------------------------------------------------+
// | ahb_sram_pkg : shared types and helpers for the AHB-Lite SRAM      |
// | Revision     : 1.0                                                 |
// +------------------------------------------------------------------+
`default_nettype none

package ahb_sram_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SIZE_BYTE   = 3'd0,
    SIZE_HALF   = 3'd1,
    SIZE_WORD   = 3'd2,
    SIZE_DWORD  = 3'd3,
    SIZE_4WORD  = 3'd4,
    SIZE_8WORD  = 3'd5,
    SIZE_16WORD = 3'd6,
    SIZE_32WORD = 3'd7
  } hsize_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } sram_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Strobe covering 2^size bytes starting at lane; callers slice to their bus width.
  function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [2:0] lane);
    logic [15:0] m;
    m = 16'((1 << (1 << size)) - 1) << lane;
    return m[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_sram_array.sv
// +------------------------------------------------------------------+
// | ahb_sram_array : DEPTH x DATA_W storage, byte-strobe write port,   |
// |                  combinational read port and monitor read port     |
// | Revision       : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

module ahb_sram_array #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4096,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              mon_en,
  input  logic [IDX_W-1:0]  mon_addr,
  output logic [DATA_W-1:0] mon_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

  always_comb begin
    mon_data = '0;
    if (mon_en && (32'(mon_addr) < DEPTH)) begin
      mon_data = mem[mon_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// +------------------------------------------------------------------+
// | ahb_sram_slave : AHB-Lite SRAM slave with wait states and ERROR    |
// |                  response. Option: AHB_SRAM_WAIT_RANDOM_EN         |
// | Revision       : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [DATA_W-1:0]        HWDATA,
  input  logic                     HREADY,
  output logic [DATA_W-1:0]        HRDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  input  logic                     monitor_flag,
  input  logic [$clog2(DEPTH)-1:0] monitor_addr,
  output logic [DATA_W-1:0]        monitor_DATA
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = 4;

  logic              accept;
  logic              start;
  logic [ADDR_W:0]   word_idx;
  logic [LANE_W-1:0] lane;
  logic [LANE_W-1:0] align_bits;
  logic              addr_err;
  logic [CNT_W-1:0]  wait_n;

  sram_state_t       state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [LANE_W-1:0] lane_q;
  hsize_t            size_q;
  logic              write_q;
  logic              hreadyout_q;
  logic              hresp_q;

  logic [DATA_W-1:0] rdata;
  logic [STRB_W-1:0] wstrb;
  logic              mem_we;

  assign accept = HSEL && HREADY && (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);
  // A new address phase is only taken while this slave is not stalling the bus.
  assign start  = accept && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

  assign word_idx   = {1'b0, HADDR} >> LANE_W;
  assign lane       = HADDR[LANE_W-1:0];
  assign align_bits = lane & LANE_W'((1 << HSIZE) - 1);
  assign addr_err   = (word_idx >= (ADDR_W+1)'(DEPTH)) ||
                      (HSIZE > 3'(LANE_W)) ||
                      (align_bits != '0);

`ifdef AHB_SRAM_WAIT_RANDOM_EN
  logic [15:0] lfsr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lfsr <= 16'hACE1;
    end else if (start) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign wait_n = CNT_W'(lfsr % 16'(WAIT_STATES + 1));
`else
  assign wait_n = CNT_W'(WAIT_STATES);
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      wait_cnt    <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      size_q      <= SIZE_BYTE;
      write_q     <= 1'b0;
    end else begin
      if (start) begin
        idx_q   <= IDX_W'(word_idx);
        lane_q  <= lane;
        size_q  <= hsize_t'(HSIZE);
        write_q <= HWRITE;
      end
      case (state)
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state       <= ST_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          // IDLE, DATA and ERR2 all hand over to the next address phase.
          if (start && addr_err) begin
            state       <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else if (start && wait_n != '0) begin
            state       <= ST_WAIT;
            wait_cnt    <= wait_n - 1'b1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_OKAY;
          end else if (start) begin
            state       <= ST_DATA;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // The write commits on the edge that closes the DATA cycle, never earlier.
  assign mem_we = (state == ST_DATA) && write_q;
  assign wstrb  = STRB_W'(byte_mask(size_q, 3'(lane_q)));

  ahb_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk      (HCLK),
    .we       (mem_we),
    .waddr    (idx_q),
    .wstrb    (wstrb),
    .wdata    (HWDATA),
    .raddr    (idx_q),
    .rdata    (rdata),
    .mon_en   (monitor_flag),
    .mon_addr (monitor_addr),
    .mon_data (monitor_DATA)
  );

  assign HRDATA    = ((state == ST_WAIT || state == ST_DATA) && !write_q) ? rdata : '0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
// +------------------------------------------------------------------+
// | tb_ahb_sram_slave : directed and random bench for ahb_sram_slave   |
// | Revision          : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ahb_sram_slave;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4096;
  localparam int IW    = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          sel, use3;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic          mon_flag;
  logic [IW-1:0] mon_addr;

  logic [DW-1:0] rdata0, rdata3, mon0, mon3;
  logic          rdy0, rdy3, resp0, resp3;
  logic          hsel0, hsel3;
  logic          c_rdy, c_resp;
  logic [DW-1:0] c_rdata, c_mon;

  assign hsel0   = sel & ~use3;
  assign hsel3   = sel & use3;
  assign c_rdy   = use3 ? rdy3   : rdy0;
  assign c_resp  = use3 ? resp3  : resp0;
  assign c_rdata = use3 ? rdata3 : rdata0;
  assign c_mon   = use3 ? mon3   : mon0;

  ahb_sram_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy0),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0),
    .monitor_flag(mon_flag), .monitor_addr(mon_addr), .monitor_DATA(mon0));

  ahb_sram_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy3),
    .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3),
    .monitor_flag(mon_flag), .monitor_addr(mon_addr), .monitor_DATA(mon3));

  // Reference memory image per DUT (index 0: zero-wait, index 1: three-wait).
  logic [31:0] mdl [2][DEPTH];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer; entered and left just after a rising edge.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wd);
    logic [31:0] idx;
    logic [1:0]  lane;
    logic        err, wresp;
    int          waits, exp_waits;
    idx       = addr >> 2;
    lane      = addr[1:0];
    err       = (idx >= DEPTH) || (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
    exp_waits = err ? 1 : (use3 ? 3 : 0);
    sel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
    mon_flag = 1'b1; mon_addr = idx[IW-1:0];
    @(posedge clk); #1;
    sel = 1'b0; htrans = 2'b00; hwdata = wd;
    waits = 0; wresp = 1'b0;
    forever begin
      @(negedge clk);
      if (c_rdy) break;
      waits++;
      wresp = wresp | c_resp;
      chk("no_early_commit", c_mon, mdl[use3][idx[IW-1:0]]);
      if (waits > 20) begin
        chk("ready_timeout", {31'b0, c_rdy}, 32'd1);
        break;
      end
    end
    chk("wait_cycles", 32'(waits), 32'(exp_waits));
    chk("resp_in_wait", {31'b0, wresp}, {31'b0, err});
    chk("final_resp", {31'b0, c_resp}, {31'b0, err});
    chk("rdata", c_rdata, (wr || err) ? 32'd0 : mdl[use3][idx[IW-1:0]]);
    if (wr && !err) begin
      for (int k = 0; k < (1 << size); k++) begin
        mdl[use3][idx[IW-1:0]][8*(lane+k) +: 8] = wd[8*(lane+k) +: 8];
      end
    end
    @(posedge clk); #1;
    chk("mem_after", c_mon, mdl[use3][idx[IW-1:0]]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    sel = 0; use3 = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0; hwdata = 0;
    mon_flag = 0; mon_addr = 0;

    // Reset values
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", {31'b0, rdy0}, 32'd1);
    chk("rst_resp0", {31'b0, resp0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_ready3", {31'b0, rdy3}, 32'd1);
    chk("rst_rdata3", rdata3, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word write / read with zero wait, then byte and half merges
    do_xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    chk("mon_word", mon0, 32'hDEADBEEF);
    do_xfer(1'b0, 32'h10, 3'd2, 32'h0);
    do_xfer(1'b1, 32'h11, 3'd0, 32'h00005A00);
    chk("byte_merge", mon0, 32'hDEAD5AEF);
    do_xfer(1'b1, 32'h12, 3'd1, 32'h12340000);
    chk("half_merge", mon0, 32'h12345AEF);
    do_xfer(1'b0, 32'h10, 3'd2, 32'h0);
    mon_flag = 1'b0; #1;
    chk("mon_disabled", mon0, 32'd0);

    // Three wait states
    use3 = 1'b1;
    do_xfer(1'b1, 32'h10, 3'd2, 32'hCAFEF00D);
    do_xfer(1'b0, 32'h10, 3'd2, 32'h0);

    // Fill a known window in both memories
    for (int u = 0; u < 2; u++) begin
      use3 = u[0];
      for (int w = 0; w < 64; w++) do_xfer(1'b1, 32'(w * 4), 3'd2, $urandom);
    end

    // Error responses: out-of-range read and misaligned half write
    for (int u = 0; u < 2; u++) begin
      use3 = u[0];
      do_xfer(1'b0, 32'h4000, 3'd2, 32'h0);
      do_xfer(1'b1, 32'h1, 3'd1, 32'hFFFFFFFF);
      do_xfer(1'b1, 32'h8, 3'd3, 32'hFFFFFFFF);
    end

    // Back-to-back write then read of the same word, zero wait
    use3 = 1'b0;
    sel = 1'b1; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    mon_flag = 1'b1; mon_addr = 12'd8;
    @(posedge clk); #1;
    hwdata = 32'hA5A5A5A5; hwrite = 1'b0;
    @(negedge clk);
    chk("b2b_wr_ready", {31'b0, rdy0}, 32'd1);
    @(posedge clk); #1;
    sel = 1'b0; htrans = 2'b00;
    mdl[0][8] = 32'hA5A5A5A5;
    @(negedge clk);
    chk("b2b_rd_ready", {31'b0, rdy0}, 32'd1);
    chk("b2b_rd_data", rdata0, 32'hA5A5A5A5);
    @(posedge clk); #1;

    // Reset while a write sits in WAIT
    use3 = 1'b1;
    sel = 1'b1; haddr = 32'h30; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    mon_addr = 12'd12;
    @(posedge clk); #1;
    sel = 1'b0; htrans = 2'b00; hwdata = 32'h0BADF00D;
    @(negedge clk);
    chk("wait_before_rst", {31'b0, rdy3}, 32'd0);
    rst_n = 1'b0; #1;
    chk("rst_async_ready", {31'b0, rdy3}, 32'd1);
    chk("rst_async_resp", {31'b0, resp3}, 32'd0);
    chk("rst_async_rdata", rdata3, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_write", mon3, mdl[1][12]);
    sel = 1'b1; htrans = 2'b00; haddr = 32'h30;
    @(posedge clk); #1;
    sel = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'b0, rdy3}, 32'd1);
    chk("idle_resp", {31'b0, resp3}, 32'd0);
    @(posedge clk); #1;

    // Random mix over the known window plus occasional out-of-range addresses
    for (int n = 0; n < 200; n++) begin
      use3 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a = 32'h4000 + 32'($urandom_range(0, 255));
      else                           a = 32'($urandom_range(0, 255));
      s = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 32'd1);
      do_xfer(1'($urandom_range(0, 1)), a, s, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
